// File: rtl/seg7_count_monitor_pkg.sv
// Shared definitions for the 7-segment count monitor.
// Segment patterns are stored as logic [0:6] so that index 0 is segment a
// and index 6 is segment g. A bit value of 1 means the segment is off.
package seg7_count_monitor_pkg;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b1100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0001100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  // The glyphs for 6 and b are identical on this display.
  localparam seg_t SEG_AMBIG = 7'b1100000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE,
    TRACK
  } state_t;

endpackage

// File: rtl/seg7_count_monitor_digit_decode.sv
// Combinational decode of one active-low 7-segment pattern into a nibble.
// Ports:
//   pattern  - segments a..g (index 0 = a), 0 = lit
//   prefer_b - resolve the shared 6/b glyph to b when set, else to 6
//   nibble   - decoded hex digit (0 when illegal)
//   legal    - pattern is one of the sixteen digit glyphs
module seg7_digit_decode
  import seg7_count_monitor_pkg::*;
(
  input  logic [0:6] pattern,
  input  logic       prefer_b,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    nibble = 4'h0;
    legal  = 1'b1;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_AMBIG: nibble = prefer_b ? 4'hB : 4'h6;  // covers both 6 and b
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_count_monitor.sv
// Monitors the two-digit 7-segment display of an 8-bit counter.
// Debounces the displayed pattern, decodes it back to a byte and checks
// that each new value is the previous value + 1 (mod 256) or a clear to 0.
// Ports:
//   Clock, Reset     - rising-edge clock, async active-high reset
//   HEX1, HEX0       - upper/lower digit segments a..g, active-low
//   value            - last accepted legal value {upper, lower}
//   valid            - one-cycle pulse when value is updated
//   locked           - set once any legal value has been accepted
//   step_err         - one-cycle pulse (with valid) on an illegal step
//   bad_pattern      - one-cycle pulse when an accepted pattern is not a digit
//   err_count        - saturating count of step_err events
module seg7_count_monitor
  import seg7_count_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [0:6] HEX1,
  input  logic [0:6] HEX0,
  output logic [7:0] value,
  output logic       valid,
  output logic       locked,
  output logic       step_err,
  output logic       bad_pattern,
  output logic [7:0] err_count
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

  state_t     state, state_n;
  seg_t       sample_hi, sample_lo;
  seg_t       last_hi, last_lo;
  logic [3:0] stable_cnt;

  logic [7:0] value_n, err_count_n, value_inc, decoded;
  logic       valid_n, locked_n, step_err_n, bad_pattern_n;
  logic [3:0] nib_hi, nib_lo;
  logic       legal_hi, legal_lo;
  logic       accept;

  assign value_inc = value + 8'd1;

  // A fresh pattern is accepted once it has been sampled STABLE_CYCLES times
  // in a row; comparing against the last accepted pattern stops a held
  // display from retriggering.
  assign accept = (stable_cnt == CNT_MAX) &&
                  ({sample_hi, sample_lo} != {last_hi, last_lo});

  // The 6/b glyph is read as b only when b is what the count should show next.
  seg7_digit_decode u_dec_hi (
    .pattern  (sample_hi),
    .prefer_b ((state == TRACK) && (value_inc[7:4] == 4'hB)),
    .nibble   (nib_hi),
    .legal    (legal_hi)
  );

  seg7_digit_decode u_dec_lo (
    .pattern  (sample_lo),
    .prefer_b ((state == TRACK) && (value_inc[3:0] == 4'hB)),
    .nibble   (nib_lo),
    .legal    (legal_lo)
  );

  assign decoded = {nib_hi, nib_lo};

  always_comb begin
    state_n       = state;
    value_n       = value;
    locked_n      = locked;
    err_count_n   = err_count;
    valid_n       = 1'b0;
    step_err_n    = 1'b0;
    bad_pattern_n = 1'b0;
    if (accept) begin
      if (legal_hi && legal_lo) begin
        valid_n = 1'b1;
        value_n = decoded;
        if (state == IDLE) begin
          locked_n = 1'b1;
          state_n  = TRACK;
        end else if ((decoded != value_inc) && (decoded != 8'h00)) begin
          step_err_n = 1'b1;
          if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
        end
      end else begin
        bad_pattern_n = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      sample_hi   <= SEG_BLANK;
      sample_lo   <= SEG_BLANK;
      last_hi     <= SEG_BLANK;
      last_lo     <= SEG_BLANK;
      stable_cnt  <= 4'd0;
      value       <= 8'h00;
      valid       <= 1'b0;
      locked      <= 1'b0;
      step_err    <= 1'b0;
      bad_pattern <= 1'b0;
      err_count   <= 8'h00;
    end else begin
      sample_hi <= HEX1;
      sample_lo <= HEX0;
      if ({HEX1, HEX0} == {sample_hi, sample_lo}) begin
        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + 4'd1;
      end else begin
        stable_cnt <= 4'd0;
      end
      if (accept) begin
        last_hi <= sample_hi;
        last_lo <= sample_lo;
      end
      state       <= state_n;
      value       <= value_n;
      valid       <= valid_n;
      locked      <= locked_n;
      step_err    <= step_err_n;
      bad_pattern <= bad_pattern_n;
      err_count   <= err_count_n;
    end
  end

endmodule
